lsu: RTL
========

// Module: lsu
// PURPOSE
//  Load/store unit between EXU and WBU. Accepts one instruction per handshake, runs one
//  AXI4-Lite data access for loads/stores, aligns and extends load data, and presents
//  the result (load data or passthrough ALU result) to WBU. Non-memory ops pass through.
// PARAMETERS
//  TIMEOUT_CYC  1023  bus wait limit per access in cycles; 0 disables timeout
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active high
//  exu_valid    in   1   EXU holds a valid instruction
//  lsu_ready    out  1   LSU can accept (high only in IDLE)
//  mem_read     in   1   instruction is a load
//  mem_write    in   1   instruction is a store (never both with mem_read)
//  mem_width    in   3   RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  alu_res      in   32  effective address / passthrough result
//  wdata        in   32  store data, unshifted (rs2)
//  wmask        in   8   byte mask from EXU; bits[3:0] used, 0 = misaligned
//  lsu_valid    out  1   result valid for WBU
//  wbu_ready    in   1   WBU accepts result
//  lsu_res      out  32  load data (extended) or alu_res
//  lsu_err      out  1   access fault / misaligned / timeout on this result
//  araddr,arvalid,arready / rdata[32],rresp[2],rvalid,rready       AXI-Lite read
//  awaddr,awvalid,awready / wdata_o[32],wstrb[4],wvalid,wready / bresp[2],bvalid,bready  write
// BEHAVIOUR
//  Reset: state IDLE; lsu_ready=0 during rst, 1 after; lsu_valid, lsu_err, all AXI valids
//   and readies = 0; lsu_res=0; timeout counter=0.
//  Accept on exu_valid && lsu_ready (rising clk): latch all inputs; EXU may change after.
//  States: IDLE, RD_A, RD_D, WR, WR_B, DONE.
//   IDLE: accept -> non-mem: DONE, lsu_res=alu_res (1-cycle latency).
//         load/store with misalignment (H at addr[0]=1, W at addr[1:0]!=0) -> DONE, err=1,
//         no bus traffic, lsu_res=0. load -> RD_A. store -> WR.
//   RD_A: arvalid=1, araddr={addr[31:2],2'b00}; on arready -> RD_D.
//   RD_D: rready=1; on rvalid -> DONE, lsu_res=extend(rdata>>(8*addr[1:0])), err=(rresp!=0).
//   WR:   awvalid and wvalid both raised on entry; each dropped independently at its own
//         handshake; wdata_o = wdata << 8*addr[1:0], wstrb=wmask[3:0]; both done -> WR_B.
//   WR_B: bready=1; on bvalid -> DONE, err=(bresp!=0), lsu_res=alu_res.
//   DONE: lsu_valid=1, outputs stable; on wbu_ready -> IDLE (no same-cycle re-accept).
//  AXI rules: valid, once high, holds with stable addr/data until its ready; never waits on
//   ready to assert valid. At most one outstanding access.
//  Extend: B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged.
//  Timeout: counter clears on accept, increments each cycle in RD_A/RD_D/WR/WR_B; reaching
//   TIMEOUT_CYC -> DONE, err=1, lsu_res=0, drop all AXI valids/readies. Late bus
//   responses after timeout are not consumed; slave must be reset separately.
//  rst mid-access: all valids/readies drop on the same edge, state IDLE; in-flight
//   transaction abandoned (system resets slave with the same rst).
//  wbu_ready ignored outside DONE; exu_valid ignored outside IDLE.
// STRUCTURE
//  lsu_pkg: mem_width codes (MW_B..MW_HU), state enum, AXI resp codes (OKAY=2'b00).
//  Sub-module lsu_load_align: combinational rdata, addr[1:0], mem_width -> 32b result.
//  FSM, latches, timeout counter in lsu.
// TESTING
//  Non-mem op alu_res=0x1234_5678 -> lsu_valid next cycle, lsu_res=0x1234_5678, no AXI.
//  LB addr 0x8000_0003, rdata=0x80FF_0000 -> araddr 0x8000_0000, lsu_res=0xFFFF_FF80.
//  LHU addr 0x8000_0002, rdata=0xBEEF_0000, arready delayed 3 cycles -> lsu_res=0x0000_BEEF.
//  SB addr 0x8000_0001 wdata=0xAB, wmask=0x02, wready before awready -> wdata_o=0x0000_AB00,
//   wstrb=0010, one write, bresp=OKAY -> err=0.
//  LW addr 0x8000_0002 -> no arvalid, lsu_valid with err=1; wbu_ready low 5 cycles ->
//   outputs stable until accepted.
//  TIMEOUT_CYC=8, arready never -> err=1 after 8 cycles; rst asserted in RD_D -> all
//   valids/readies 0 next edge, lsu_ready=1 after rst drops.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  // RISC-V funct3 encodings for memory access width
  typedef enum logic [2:0] {
    MW_B  = 3'b000,
    MW_H  = 3'b001,
    MW_W  = 3'b010,
    MW_BU = 3'b100,
    MW_HU = 3'b101
  } mem_width_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_D = 3'd2,
    S_WR   = 3'd3,
    S_WR_B = 3'd4,
    S_DONE = 3'd5
  } lsu_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [2:0] width, input logic [1:0] offset);
    case (width[1:0])
      2'b01:   is_misaligned = offset[0];
      2'b10:   is_misaligned = (offset != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Moves the addressed byte/halfword of a bus word down to bit 0 and extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  width_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;
  assign shifted = rdata_i >> {offset_i, 3'b000};

  // Select sign or zero extension from the access width
  always_comb begin
    result_o = shifted;
    case (width_i)
      MW_B:    result_o = {{24{shifted[7]}}, shifted[7:0]};
      MW_BU:   result_o = {24'h0, shifted[7:0]};
      MW_H:    result_o = {{16{shifted[15]}}, shifted[15:0]};
      MW_HU:   result_o = {16'h0, shifted[15:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one AXI4-Lite access per memory instruction, result handed to WBU.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exu_valid,
  output logic        lsu_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_width,
  input  logic [31:0] alu_res,
  input  logic [31:0] wdata,
  input  logic [7:0]  wmask,
  output logic        lsu_valid,
  input  logic        wbu_ready,
  output logic [31:0] lsu_res,
  output logic        lsu_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  lsu_state_e  state_q;
  logic [31:0] addr_q;
  logic [2:0]  width_q;
  logic [CW-1:0] cnt_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic [31:0] araddr_q, awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        lsu_valid_q, lsu_err_q;
  logic [31:0] lsu_res_q;

  logic [31:0] load_res;
  logic        in_bus, completing, timeout;
  logic        aw_ok, w_ok;
  logic        unused_wmask;

  assign unused_wmask = ^wmask[7:4];

  lsu_load_align u_align (
    .rdata_i  (rdata),
    .offset_i (addr_q[1:0]),
    .width_i  (width_q),
    .result_o (load_res)
  );

  assign in_bus     = (state_q == S_RD_A) || (state_q == S_RD_D) ||
                      (state_q == S_WR)   || (state_q == S_WR_B);
  // A response arriving on the deadline cycle is still taken.
  assign completing = ((state_q == S_RD_D) && rvalid) || ((state_q == S_WR_B) && bvalid);
  assign timeout    = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);
  assign aw_ok      = !awvalid_q || awready;
  assign w_ok       = !wvalid_q || wready;

  // Main FSM: latches the instruction, drives the bus channels, produces the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      width_q     <= '0;
      cnt_q       <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      lsu_valid_q <= 1'b0;
      lsu_err_q   <= 1'b0;
      lsu_res_q   <= '0;
    end else begin
      if (in_bus) cnt_q <= cnt_q + 1'b1;
      case (state_q)
        S_IDLE: if (exu_valid) begin
          addr_q  <= alu_res;
          width_q <= mem_width;
          cnt_q   <= '0;
          if (!mem_read && !mem_write) begin
            state_q     <= S_DONE;
            lsu_valid_q <= 1'b1;
            lsu_err_q   <= 1'b0;
            lsu_res_q   <= alu_res;
          end else if (is_misaligned(mem_width, alu_res[1:0])) begin
            state_q     <= S_DONE;
            lsu_valid_q <= 1'b1;
            lsu_err_q   <= 1'b1;
            lsu_res_q   <= '0;
          end else if (mem_read) begin
            state_q   <= S_RD_A;
            arvalid_q <= 1'b1;
            araddr_q  <= {alu_res[31:2], 2'b00};
          end else begin
            state_q   <= S_WR;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= {alu_res[31:2], 2'b00};
            wdata_q   <= wdata << {alu_res[1:0], 3'b000};
            wstrb_q   <= wmask[3:0];
          end
        end
        S_RD_A: if (arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= S_RD_D;
        end
        S_RD_D: if (rvalid) begin
          rready_q    <= 1'b0;
          state_q     <= S_DONE;
          lsu_valid_q <= 1'b1;
          lsu_res_q   <= load_res;
          lsu_err_q   <= (rresp != RESP_OKAY);
        end
        S_WR: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready)   wvalid_q  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_B;
          end
        end
        S_WR_B: if (bvalid) begin
          bready_q    <= 1'b0;
          state_q     <= S_DONE;
          lsu_valid_q <= 1'b1;
          lsu_res_q   <= addr_q;
          lsu_err_q   <= (bresp != RESP_OKAY);
        end
        S_DONE: if (wbu_ready) begin
          lsu_valid_q <= 1'b0;
          lsu_err_q   <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // Deadline overrides any channel progress made above
      if (in_bus && timeout && !completing) begin
        arvalid_q   <= 1'b0;
        rready_q    <= 1'b0;
        awvalid_q   <= 1'b0;
        wvalid_q    <= 1'b0;
        bready_q    <= 1'b0;
        state_q     <= S_DONE;
        lsu_valid_q <= 1'b1;
        lsu_err_q   <= 1'b1;
        lsu_res_q   <= '0;
      end
    end
  end

  assign lsu_ready = (state_q == S_IDLE) && !rst;
  assign lsu_valid = lsu_valid_q;
  assign lsu_err   = lsu_err_q;
  assign lsu_res   = lsu_res_q;
  assign araddr    = araddr_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign awaddr    = awaddr_q;
  assign awvalid   = awvalid_q;
  assign wdata_o   = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;

endmodule
